// File: rtl/pipe_mux_n_if.sv
// rtl/pipe_mux_n_if.sv - operand selector stream interface
//
// Groups the input beat (in_flat/in_sel/in_valid/in_ready) and the output
// beat (out_data/out_sel/out_err/out_valid/out_ready) plus occupancy.
// slave  : view of the selector block itself.
// master : view of the surrounding datapath / testbench.
interface pipe_mux_n_if #(
   parameter int NUM_IN = 4,
   parameter int WIDTH  = 32,
   parameter int SEL_W  = 2
);
   logic [NUM_IN*WIDTH-1:0] in_flat;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;
   logic [2:0]              occupancy;

   modport slave (
      input  in_flat, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_err, out_valid, occupancy
   );

   modport master (
      output in_flat, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_err, out_valid, occupancy
   );
endinterface

// File: rtl/pipe_mux_n.sv
// rtl/pipe_mux_n.sv - N-way WIDTH-bit selector with STAGES-deep elastic pipeline
//
// Selects one of NUM_IN packed inputs by in_sel, then carries {data, sel, err}
// through STAGES registered stages with a valid/ready handshake.
// Optional feature macro: PIPE_MUX_SEL_CHECK_EN (out-of-range select flags err
// and zeroes the data; without it such selects pick input 0 and err is 0).
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous reset, active low
//   bus       pipe_mux_n_if.slave:
//               in_flat/in_sel/in_valid -> in_ready
//               out_data/out_sel/out_err/out_valid <- out_ready
//               occupancy = number of valid stages
module pipe_mux_n #(
   parameter int NUM_IN = 4,
   parameter int WIDTH  = 32,
   parameter int SEL_W  = 2,
   parameter int STAGES = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   pipe_mux_n_if.slave  bus
);
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_nxt;
   logic [STAGES-1:0] up_v;
   logic [STAGES-1:0] rdy;
   logic [WIDTH-1:0]  data_q  [STAGES];
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [SEL_W-1:0]  sel_q   [STAGES];
   logic [SEL_W-1:0]  up_sel  [STAGES];
   logic [2:0]        occ_q;
   logic [2:0]        occ_nxt;
   logic [WIDTH-1:0]  mux_data;
`ifdef PIPE_MUX_SEL_CHECK_EN
   logic              sel_err;
   logic [STAGES-1:0] err_q;
   logic [STAGES-1:0] up_err;
`endif

   // Mux is evaluated only at the input; later stages just move captured beats.
   always_comb begin : input_mux
      mux_data = bus.in_flat[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            mux_data = bus.in_flat[k*WIDTH +: WIDTH];
         end
      end
`ifdef PIPE_MUX_SEL_CHECK_EN
      sel_err = ({1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_IN));
      if (sel_err) begin
         mux_data = '0;
      end
`endif
   end

   // Ready ripples back from out_ready; an empty stage is always ready so
   // bubbles collapse. Uses a running scalar to keep the chain acyclic.
   always_comb begin : ready_chain
      logic r;
      rdy = '0;
      r   = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r      = ~v_q[k] | r;
         rdy[k] = r;
      end
   end

   // Upstream view of each stage, next valid bits and next occupancy.
   always_comb begin : upstream
      up_v[0]    = bus.in_valid;
      up_data[0] = mux_data;
      up_sel[0]  = bus.in_sel;
`ifdef PIPE_MUX_SEL_CHECK_EN
      up_err[0]  = sel_err;
`endif
      for (int k = 1; k < STAGES; k++) begin
         up_v[k]    = v_q[k-1];
         up_data[k] = data_q[k-1];
         up_sel[k]  = sel_q[k-1];
`ifdef PIPE_MUX_SEL_CHECK_EN
         up_err[k]  = err_q[k-1];
`endif
      end
      v_nxt   = '0;
      occ_nxt = '0;
      for (int k = 0; k < STAGES; k++) begin
         v_nxt[k] = rdy[k] ? up_v[k] : v_q[k];
         occ_nxt  = occ_nxt + {2'b00, v_nxt[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            sel_q[k]  <= '0;
         end
`ifdef PIPE_MUX_SEL_CHECK_EN
         err_q <= '0;
`endif
      end else begin
         v_q   <= v_nxt;
         occ_q <= occ_nxt;
         // Payload only moves with a valid beat; a bubble leaves old payload
         // in place, which is harmless because v is cleared.
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k] && up_v[k]) begin
               data_q[k] <= up_data[k];
               sel_q[k]  <= up_sel[k];
`ifdef PIPE_MUX_SEL_CHECK_EN
               err_q[k]  <= up_err[k];
`endif
            end
         end
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.out_data  = data_q[STAGES-1];
   assign bus.out_sel   = sel_q[STAGES-1];
   assign bus.occupancy = occ_q;
`ifdef PIPE_MUX_SEL_CHECK_EN
   assign bus.out_err   = err_q[STAGES-1];
`else
   assign bus.out_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_mux_n.sv
// tb/tb_pipe_mux_n.sv - self-checking bench for pipe_mux_n
module tb_pipe_mux_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst_d;

   pipe_mux_n_if #(.NUM_IN(4), .WIDTH(32), .SEL_W(2)) ba ();
   pipe_mux_n_if #(.NUM_IN(4), .WIDTH(32), .SEL_W(2)) bb ();
   pipe_mux_n_if #(.NUM_IN(5), .WIDTH(32), .SEL_W(3)) bc ();
   pipe_mux_n_if #(.NUM_IN(4), .WIDTH(32), .SEL_W(2)) bd ();

   pipe_mux_n #(.NUM_IN(4), .WIDTH(32), .SEL_W(2), .STAGES(2)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ba.slave));
   pipe_mux_n #(.NUM_IN(4), .WIDTH(32), .SEL_W(2), .STAGES(3)) dut_b (.clk(clk), .reset_n(rst_n), .bus(bb.slave));
   pipe_mux_n #(.NUM_IN(5), .WIDTH(32), .SEL_W(3), .STAGES(1)) dut_c (.clk(clk), .reset_n(rst_n), .bus(bc.slave));
   pipe_mux_n #(.NUM_IN(4), .WIDTH(32), .SEL_W(2), .STAGES(4)) dut_d (.clk(clk), .reset_n(rst_d), .bus(bd.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        vld;
      logic [1:0]  sel;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_data;
      logic [1:0]  e_sel;
      logic [2:0]  e_occ;
   } vec_t;

   function automatic vec_t mk(input logic vld, input logic [1:0] sel, input logic ordy,
                               input logic e_ir, input logic e_ov, input logic [31:0] e_data,
                               input logic [1:0] e_sel, input logic [2:0] e_occ);
      vec_t t;
      t.vld = vld; t.sel = sel; t.ordy = ordy; t.e_ir = e_ir;
      t.e_ov = e_ov; t.e_data = e_data; t.e_sel = e_sel; t.e_occ = e_occ;
      return t;
   endfunction

   vec_t vt [15];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] exp_d;
      logic        exp_e;

      // Streaming with out_ready=1, then backpressure on the 2-stage instance.
      vt[0]  = mk(1, 0, 1, 1, 0, 32'h0,  0, 0);
      vt[1]  = mk(1, 1, 1, 1, 0, 32'h0,  0, 1);
      vt[2]  = mk(1, 2, 1, 1, 1, 32'hA0, 0, 2);
      vt[3]  = mk(1, 3, 1, 1, 1, 32'hB1, 1, 2);
      vt[4]  = mk(0, 0, 1, 1, 1, 32'hC2, 2, 2);
      vt[5]  = mk(0, 0, 1, 1, 1, 32'hD3, 3, 1);
      vt[6]  = mk(0, 0, 1, 1, 0, 32'h0,  0, 0);
      vt[7]  = mk(1, 0, 0, 1, 0, 32'h0,  0, 0);
      vt[8]  = mk(1, 1, 0, 1, 0, 32'h0,  0, 1);
      vt[9]  = mk(1, 2, 0, 0, 1, 32'hA0, 0, 2);
      vt[10] = mk(1, 2, 0, 0, 1, 32'hA0, 0, 2);
      vt[11] = mk(1, 2, 1, 1, 1, 32'hA0, 0, 2);
      vt[12] = mk(0, 0, 1, 1, 1, 32'hB1, 1, 2);
      vt[13] = mk(0, 0, 1, 1, 1, 32'hC2, 2, 1);
      vt[14] = mk(0, 0, 1, 1, 0, 32'h0,  0, 0);

      ba.in_flat = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
      bb.in_flat = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
      bd.in_flat = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
      bc.in_flat = {32'h44, 32'h33, 32'h22, 32'h11, 32'h1234_5678};
      ba.in_sel = '0; bb.in_sel = '0; bc.in_sel = '0; bd.in_sel = '0;
      ba.in_valid = 1'b1; bb.in_valid = 1'b0; bc.in_valid = 1'b0; bd.in_valid = 1'b0;
      ba.out_ready = 1'b1; bb.out_ready = 1'b0; bc.out_ready = 1'b1; bd.out_ready = 1'b0;

      // Reset held 3 cycles with in_valid=1.
      rst_n = 1'b0;
      rst_d = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_out_valid", {31'b0, ba.out_valid}, 32'd0);
      chk("rst_occupancy", {29'b0, ba.occupancy}, 32'd0);
      chk("rst_out_data", ba.out_data, 32'd0);
      chk("rst_out_sel", {30'b0, ba.out_sel}, 32'd0);
      chk("rst_out_err", {31'b0, ba.out_err}, 32'd0);
      chk("rst_occ_d", {29'b0, bd.occupancy}, 32'd0);
      ba.in_valid = 1'b0;
      rst_n = 1'b1;
      rst_d = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_in_ready", {31'b0, ba.in_ready}, 32'd1);
      chk("post_rst_occupancy", {29'b0, ba.occupancy}, 32'd0);

      // Table-driven streaming / backpressure on STAGES=2.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         ba.in_valid  = vt[i].vld;
         ba.in_sel    = vt[i].sel;
         ba.out_ready = vt[i].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", i), {31'b0, ba.in_ready}, {31'b0, vt[i].e_ir});
         chk($sformatf("vec%0d_out_valid", i), {31'b0, ba.out_valid}, {31'b0, vt[i].e_ov});
         chk($sformatf("vec%0d_occupancy", i), {29'b0, ba.occupancy}, {29'b0, vt[i].e_occ});
         if (vt[i].e_ov) begin
            chk($sformatf("vec%0d_out_data", i), ba.out_data, vt[i].e_data);
            chk($sformatf("vec%0d_out_sel", i), {30'b0, ba.out_sel}, {30'b0, vt[i].e_sel});
            chk($sformatf("vec%0d_out_err", i), {31'b0, ba.out_err}, 32'd0);
         end
      end

      // Full-and-consume on STAGES=3.
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         bb.in_valid = 1'b1;
         bb.in_sel   = 2'(s);
         #1;
         chk($sformatf("fill%0d_in_ready", s), {31'b0, bb.in_ready}, 32'd1);
      end
      @(negedge clk);
      bb.in_sel = 2'd3;
      #1;
      chk("full_occupancy", {29'b0, bb.occupancy}, 32'd3);
      chk("full_in_ready", {31'b0, bb.in_ready}, 32'd0);
      chk("full_out_data", bb.out_data, 32'hA0);
      bb.out_ready = 1'b1;
      #1;
      chk("consume_in_ready", {31'b0, bb.in_ready}, 32'd1);
      @(negedge clk);
      bb.in_valid = 1'b0;
      #1;
      chk("consume_occupancy", {29'b0, bb.occupancy}, 32'd3);
      chk("consume_out_data", bb.out_data, 32'hB1);
      @(negedge clk); #1;
      chk("drain1_out_data", bb.out_data, 32'hC2);
      chk("drain1_occupancy", {29'b0, bb.occupancy}, 32'd2);
      @(negedge clk); #1;
      chk("drain2_out_data", bb.out_data, 32'hD3);
      chk("drain2_out_sel", {30'b0, bb.out_sel}, 32'd3);
      @(negedge clk); #1;
      chk("drain3_out_valid", {31'b0, bb.out_valid}, 32'd0);

      // Out-of-range select on NUM_IN=5, SEL_W=3, STAGES=1.
`ifdef PIPE_MUX_SEL_CHECK_EN
      exp_d = 32'h0;
      exp_e = 1'b1;
`else
      exp_d = 32'h1234_5678;
      exp_e = 1'b0;
`endif
      @(negedge clk);
      bc.in_valid = 1'b1;
      bc.in_sel   = 3'd6;
      @(negedge clk);
      bc.in_sel = 3'd4;
      #1;
      chk("oor_out_valid", {31'b0, bc.out_valid}, 32'd1);
      chk("oor_out_data", bc.out_data, exp_d);
      chk("oor_out_err", {31'b0, bc.out_err}, {31'b0, exp_e});
      chk("oor_out_sel", {29'b0, bc.out_sel}, 32'd6);
      @(negedge clk);
      bc.in_valid = 1'b0;
      #1;
      chk("sel4_out_data", bc.out_data, 32'h44);
      chk("sel4_out_err", {31'b0, bc.out_err}, 32'd0);
      chk("sel4_out_sel", {29'b0, bc.out_sel}, 32'd4);

      // Mid-flight reset on STAGES=4.
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         bd.in_valid = 1'b1;
         bd.in_sel   = 2'(s);
      end
      @(negedge clk);
      bd.in_valid = 1'b0;
      #1;
      chk("inflight_occupancy", {29'b0, bd.occupancy}, 32'd3);
      rst_d = 1'b0;
      @(negedge clk);
      rst_d = 1'b1;
      #1;
      chk("midrst_occupancy", {29'b0, bd.occupancy}, 32'd0);
      chk("midrst_out_valid", {31'b0, bd.out_valid}, 32'd0);
      bd.out_ready = 1'b1;
      bd.in_valid  = 1'b1;
      bd.in_sel    = 2'd3;
      n = 0;
      do begin
         @(negedge clk);
         bd.in_valid = 1'b0;
         #1;
         n++;
      end while (!bd.out_valid && n < 20);
      chk("midrst_latency", n, 32'd4);
      chk("midrst_out_data", bd.out_data, 32'hD3);
      chk("midrst_out_sel", {30'b0, bd.out_sel}, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised N-way, WIDTH-bit selector that replaces fixed 4-input 32-bit operand muxes in the multicycle datapath.
- Registers its result through a STAGES-deep elastic pipeline with a valid/ready handshake.
- Tags each result with the select value that produced it.
- Sits between register-file/immediate sources and the ALU operand or memory-address registers.

Parameters:
- NUM_IN, 4, number of data inputs; legal range 2..16.
- WIDTH, 32, data width in bits.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- STAGES, 1, pipeline depth in registers; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active low.
- in_flat  input  NUM_IN*WIDTH  packed data inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select for the current beat.
- in_valid  input  1  beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  WIDTH  selected data.
- out_sel  output  SEL_W  select value captured with out_data.
- out_err  output  1  beat carried an out-of-range select (see Optional Feature).
- out_valid  output  1  out_data, out_sel and out_err are valid.
- out_ready  input  1  downstream consumes the beat.
- occupancy  output  3  number of valid stages, 0..STAGES.

Behaviour:
- One clock. Reset is synchronous and active-low: the reset_n port is sampled only on the rising edge of clk.
- Reset clears every stage: all valid bits 0, data 0, sel 0, err 0. Consequently out_valid=0, out_data=0, out_sel=0, out_err=0, occupancy=0.
- in_ready is don't-care during reset. The cycle after reset_n rises, in_ready=1.
- Stage k holds {v, data, sel, err}. Stage 0 is the input stage; stage STAGES-1 drives the outputs.
- Ready chain:
  - ready[STAGES] = out_ready.
  - ready[k] = ~v[k] | ready[k+1].
  - in_ready = ready[0]. This is a combinational path through the stages; there is no combinational path from in_valid to in_ready.
- Stage k loads from stage k-1 (or from the input, for k=0) when ready[k]=1.
  - The loaded v equals the upstream v (or in_valid for stage 0).
  - Bubbles collapse: an empty stage always loads.
- Mux is evaluated at the input only. Stage 0 captures in_flat[in_sel*WIDTH +: WIDTH] and in_sel in the cycle in_valid & in_ready.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Latency: STAGES cycles from input transfer to out_valid, given an empty pipeline.
- Throughput: one beat per cycle when out_ready is held at 1.
- Stall: with out_ready=0, the stages fill; in_ready falls once all STAGES stages are valid.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- Simultaneous input and output transfer when full: accepted, occupancy unchanged.
- occupancy = popcount of the v bits, updated registered with the stages.
- in_flat changes after capture do not affect captured beats.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.

Optional Feature:
- Macro: PIPE_MUX_SEL_CHECK_EN.
- Defined:
  - in_sel >= NUM_IN captures data=0 and err=1, and out_sel carries the raw in_sel value.
  - The beat still flows through the pipeline normally.
- Undefined:
  - in_sel >= NUM_IN selects input 0 data.
  - err is always 0, and out_err is tied to 0.
  - No range comparator is synthesised.

Test Plan:
- Reset with NUM_IN=4, STAGES=2: hold reset_n=0 for 3 cycles with in_valid=1 -> out_valid=0, occupancy=0, out_data=0. One cycle after reset_n=1 -> in_ready=1.
- Streaming with NUM_IN=4, STAGES=2, out_ready=1: inputs 0xA0,0xB1,0xC2,0xD3, in_sel cycling 0,1,2,3 on consecutive cycles -> out_data sequence 0xA0,0xB1,0xC2,0xD3 with out_sel 0..3. First out_valid occurs 2 cycles after the first accept; there are no gaps.
- Backpressure with STAGES=2: drive out_ready=0 and offer 3 beats -> 2 accepted, then in_ready=0 and occupancy=2, with outputs stable. Raise out_ready -> beats emerge in order, nothing lost or duplicated.
- Full-and-consume with STAGES=3 full: out_ready=1 and in_valid=1 in the same cycle -> one beat in, one beat out, occupancy stays 3.
- Out-of-range select with NUM_IN=5, SEL_W=3, in_sel=6:
  - With PIPE_MUX_SEL_CHECK_EN -> out_data=0, out_err=1, out_sel=6.
  - Without the macro -> out_data = input 0, out_err=0.
- Mid-flight reset with STAGES=4 and 3 beats in flight: pulse reset_n=0 for 1 cycle -> next cycle occupancy=0 and out_valid=0. The following beat emerges after exactly 4 cycles.
